// File: rtl/playback_packet_reader.sv
// playback_packet_reader
//
// Playback-side reader for the 32-bit audio packet stream. A play command
// opens a prepacket slot of 32 bit ticks during which packet 0 is prefetched
// from sample memory. The block then serializes NUM_PACKETS words MSB-first,
// one bit per bit_tick. While each word is being shifted out, the next word is
// fetched one packet ahead into a holding buffer.
//
// Optional feature macro: PLAYBACK_LOOP_EN
//   Undefined (default): a single pass through the recording, then back to IDLE
//                        with a one-cycle done pulse.
//   Defined:             after the last packet the stream continues seamlessly
//                        with packet 0. done pulses at every wrap, and no new
//                        prepacket slot is inserted.
//
// Parameters
//   NUM_PACKETS  packets per recording (2**ADDR_W >= NUM_PACKETS, <= 1024)
//   ADDR_W       sample memory address width
//
// Ports
//   clk           single clock
//   reset         synchronous, active-high reset
//   Play_butt     start / restart playback (sampled every cycle)
//   Rec_butt      abort playback (sampled every cycle, beats Play_butt)
//   bit_tick      one-cycle strobe per serial bit slot (>= 3 cycles apart)
//   mem_rd_en     memory read strobe
//   mem_addr      memory read address
//   mem_rd_data   read data, valid exactly one cycle after mem_rd_en
//   sdata_out     serial output bit
//   bit_count     bit index within the current packet (0..31)
//   packet_count  index of the packet being output
//   prepacket     high during the prefetch slot
//   playing       high while in PREPACKET or STREAM
//   done          one-cycle pulse at the end of a recording

module playback_packet_reader #(
    parameter int NUM_PACKETS = 937,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Play_butt,
    input  logic              Rec_butt,
    input  logic              bit_tick,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              sdata_out,
    output logic [4:0]        bit_count,
    output logic [9:0]        packet_count,
    output logic              prepacket,
    output logic              playing,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        PREPACKET,
        STREAM
    } state_t;

    localparam logic [9:0]  LAST_PACKET = 10'(NUM_PACKETS - 1);
    localparam logic [10:0] PACKET_END  = 11'(NUM_PACKETS);

    state_t state;
    state_t state_next;

    logic [31:0] shift_reg;
    logic [31:0] next_buf;
    logic        rd_pending;

    logic do_abort;
    logic do_start;
    logic do_step;
    logic do_shift;
    logic do_load;
    logic do_wrap;
    logic do_finish;

    logic [9:0]        load_pc;
    logic [10:0]       fetch_idx;
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;

    // State register. Everything else hangs off the decoded control strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode. Rec_butt beats Play_butt, and both beat
    // bit_tick, so a tick arriving with either button is dropped.
    // In PREPACKET, the bit-31 tick loads the prefetched packet 0 and enters
    // STREAM. In STREAM, the bit-31 tick either loads the next packet or ends
    // the recording. In the looping build, the end of the recording is
    // replaced by a wrap back to packet 0.
    always_comb begin
        state_next = state;
        do_abort   = 1'b0;
        do_start   = 1'b0;
        do_step    = 1'b0;
        do_shift   = 1'b0;
        do_load    = 1'b0;
        do_wrap    = 1'b0;
        do_finish  = 1'b0;
        if (Rec_butt) begin
            state_next = IDLE;
            do_abort   = 1'b1;
        end else if (Play_butt) begin
            state_next = PREPACKET;
            do_start   = 1'b1;
        end else if (bit_tick) begin
            case (state)
                PREPACKET: begin
                    if (bit_count == 5'd31) begin
                        state_next = STREAM;
                        do_load    = 1'b1;
                    end else begin
                        do_step = 1'b1;
                    end
                end
                STREAM: begin
                    if (bit_count != 5'd31) begin
                        do_shift = 1'b1;
                    end else if (packet_count != LAST_PACKET) begin
                        do_load = 1'b1;
                    end else begin
`ifdef PLAYBACK_LOOP_EN
                        do_load = 1'b1;
                        do_wrap = 1'b1;
`else
                        state_next = IDLE;
                        do_finish  = 1'b1;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Work out which packet a load makes current, and which address the
    // one-ahead prefetch should read.
    // The prepacket exit and a loop wrap both make packet 0 current;
    // otherwise the packet index advances by one. The prefetch targets the
    // packet after the new current one. In the single-pass build, the read
    // is suppressed once that address runs past the recording. In the
    // looping build, the read wraps round to address 0 instead.
    always_comb begin
        load_pc = packet_count + 10'd1;
        if (state == PREPACKET || do_wrap) begin
            load_pc = 10'd0;
        end
        fetch_idx  = {1'b0, load_pc} + 11'd1;
        fetch_en   = 1'b0;
        fetch_addr = '0;
`ifdef PLAYBACK_LOOP_EN
        fetch_en = 1'b1;
        if (fetch_idx != PACKET_END) begin
            fetch_addr = ADDR_W'(fetch_idx);
        end
`else
        if (fetch_idx < PACKET_END) begin
            fetch_en   = 1'b1;
            fetch_addr = ADDR_W'(fetch_idx);
        end
`endif
    end

    // Datapath: counters, shift register, prefetch buffer and memory port.
    // rd_pending marks the cycle in which read data is on mem_rd_data.
    // An abort or restart clears it and blocks that cycle's capture, so a
    // read issued before the restart can never leak into the new sequence.
    // Loads happen at least 3 cycles apart, while the capture completes 2
    // cycles after the load that issued it. next_buf is therefore settled
    // before it is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg    <= 32'd0;
            next_buf     <= 32'd0;
            rd_pending   <= 1'b0;
            bit_count    <= 5'd0;
            packet_count <= 10'd0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            done         <= 1'b0;
        end else begin
            mem_rd_en  <= 1'b0;
            done       <= 1'b0;
            rd_pending <= mem_rd_en;
            if (rd_pending && !do_abort && !do_start) begin
                next_buf <= mem_rd_data;
            end
            if (do_abort || do_finish) begin
                bit_count    <= 5'd0;
                packet_count <= 10'd0;
                mem_addr     <= '0;
                done         <= do_finish;
                if (do_abort) begin
                    rd_pending <= 1'b0;
                end
            end else if (do_start) begin
                bit_count    <= 5'd0;
                packet_count <= 10'd0;
                mem_rd_en    <= 1'b1;
                mem_addr     <= '0;
                rd_pending   <= 1'b0;
            end else if (do_step) begin
                bit_count <= bit_count + 5'd1;
            end else if (do_shift) begin
                shift_reg <= {shift_reg[30:0], 1'b0};
                bit_count <= bit_count + 5'd1;
            end else if (do_load) begin
                shift_reg    <= next_buf;
                bit_count    <= 5'd0;
                packet_count <= load_pc;
                mem_rd_en    <= fetch_en;
                done         <= do_wrap;
                if (fetch_en) begin
                    mem_addr <= fetch_addr;
                end
            end
        end
    end

    // Status outputs are straight decodes of the state register. The serial
    // bit is only driven while streaming.
    assign playing   = (state != IDLE);
    assign prepacket = (state == PREPACKET);
    assign sdata_out = (state == STREAM) && shift_reg[31];

endmodule

// File: tb/tb_playback_packet_reader.sv
// tb_playback_packet_reader
//
// Directed scenarios with randomized tick spacing and memory contents,
// followed by a random button/tick phase. Every cycle's outputs are compared
// against a reference model. The model tracks playback as "ticks accepted
// since the last play command". From that count it derives the prepacket
// slot, the packet/bit position, the expected serial bit, and the expected
// memory reads.

module tb_playback_packet_reader;

    localparam int N  = 24;
    localparam int AW = 5;
`ifdef PLAYBACK_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          Play_butt;
    logic          Rec_butt;
    logic          bit_tick;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rd_data;
    logic          sdata_out;
    logic [4:0]    bit_count;
    logic [9:0]    packet_count;
    logic          prepacket;
    logic          playing;
    logic          done;

    playback_packet_reader #(
        .NUM_PACKETS(N),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clock),
        .reset       (reset),
        .Play_butt   (Play_butt),
        .Rec_butt    (Rec_butt),
        .bit_tick    (bit_tick),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .sdata_out   (sdata_out),
        .bit_count   (bit_count),
        .packet_count(packet_count),
        .prepacket   (prepacket),
        .playing     (playing),
        .done        (done)
    );

    logic [31:0] mem [0:(1<<AW)-1];

    int numChecks = 0;
    int numFails  = 0;

    // reference model state
    bit mActive  = 1'b0;
    int mPos     = 0;
    bit expRdEn  = 1'b0;
    int expAddr  = 0;
    bit expDone  = 1'b0;

    // memory responder state
    bit          prevEn   = 1'b0;
    logic [AW-1:0] prevAddr = '0;
    int          sinceTick = 10;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        assert (observed === expected) else begin
            numFails++;
            $error("[TB] FAIL %s at %0t: observed %h expected %h", tag, $time, observed, expected);
        end
    endtask

    // Advance the model by one clock edge, given the inputs sampled there.
    task automatic modelEdge(input bit r, input bit rc, input bit pl, input bit tk);
        int k;
        expRdEn = 1'b0;
        expDone = 1'b0;
        if (r || rc) begin
            mActive = 1'b0;
            mPos    = 0;
        end else if (pl) begin
            mActive = 1'b1;
            mPos    = 0;
            expRdEn = 1'b1;
            expAddr = 0;
        end else if (tk && mActive) begin
            mPos++;
            if (mPos % 32 == 0) begin
                // k-th slot just completed; stream packet k-1 becomes current
                k = mPos / 32;
                if (!LOOP && (k - 1) == N) begin
                    mActive = 1'b0;
                    mPos    = 0;
                    expDone = 1'b1;
                end else if (LOOP) begin
                    if ((k - 1) > 0 && ((k - 1) % N) == 0) expDone = 1'b1;
                    expRdEn = 1'b1;
                    expAddr = k % N;
                end else if (k < N) begin
                    expRdEn = 1'b1;
                    expAddr = k;
                end
            end
        end
    endtask

    task automatic checkCycle();
        int rel;
        int pkt;
        int bitIdx;
        logic [31:0] word;
        bit expSdata;
        bitIdx   = mPos % 32;
        pkt      = 0;
        expSdata = 1'b0;
        if (mActive && mPos >= 32) begin
            rel      = mPos - 32;
            pkt      = (rel / 32) % N;
            word     = mem[pkt];
            expSdata = word[31 - bitIdx];
        end
        checkOutput("playing", 32'(playing), 32'(mActive));
        checkOutput("prepacket", 32'(prepacket), 32'(mActive && mPos < 32));
        checkOutput("bit_count", 32'(bit_count), mActive ? 32'(bitIdx) : 32'd0);
        checkOutput("packet_count", 32'(packet_count), 32'(pkt));
        checkOutput("sdata_out", 32'(sdata_out), 32'(expSdata));
        checkOutput("done", 32'(done), 32'(expDone));
        checkOutput("mem_rd_en", 32'(mem_rd_en), 32'(expRdEn));
        if (expRdEn) begin
            checkOutput("mem_addr", 32'(mem_addr), 32'(expAddr));
        end
    endtask

    // One clock cycle: drive inputs, step the model at the edge, then at the
    // falling edge serve memory data and compare all outputs.
    task automatic applyStimulus(input bit r, input bit rc, input bit pl, input bit tk);
        reset     = r;
        Rec_butt  = rc;
        Play_butt = pl;
        bit_tick  = tk;
        @(posedge clock);
        modelEdge(r, rc, pl, tk);
        @(negedge clock);
        mem_rd_data = prevEn ? mem[prevAddr] : $urandom;
        prevEn      = (mem_rd_en === 1'b1);
        prevAddr    = mem_addr;
        checkCycle();
        sinceTick   = tk ? 0 : sinceTick + 1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic runTicks(input int count);
        for (int i = 0; i < count; i++) begin
            idleCycles($urandom_range(2, 5));
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        reset       = 1'b1;
        Play_butt   = 1'b0;
        Rec_butt    = 1'b0;
        bit_tick    = 1'b0;
        mem_rd_data = 32'd0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;

        $display("[TB] reset state");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] ticks while idle");
        runTicks(4);

        $display("[TB] full pass");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        runTicks((N + 1) * 32 + 6);
        idleCycles(4);

        $display("[TB] abort at packet 10 bit 10");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        runTicks(32 + 10 * 32 + 10);
        idleCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        runTicks(6);

        $display("[TB] restart at packet 5");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        runTicks(32 + 5 * 32 + 7);
        idleCycles(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        runTicks(32 * 3 + 5);

        $display("[TB] rec and play together");
        idleCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        runTicks(5);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        runTicks(32 * 2 + 3);
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        runTicks(5);

        $display("[TB] random buttons and ticks");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 4000; c++) begin
            int  r;
            bit  tk;
            r  = int'($urandom_range(0, 1199));
            tk = (sinceTick >= 2) && ($urandom_range(0, 2) == 0);
            applyStimulus(r == 7, (r % 400) == 1, (r % 250) == 3, tk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/playback_packet_reader.md
# playback_packet_reader

Playback-side reader for the 32-bit audio packet stream. On a play command it runs one prepacket slot to prefetch packet 0 from sample memory, then serializes `NUM_PACKETS` 32-bit words MSB-first, one bit per `bit_tick`, while fetching each next word one packet ahead. It sits between the sample BRAM and the serial audio output, and is the read counterpart of the record-side packet capture path.

## Interface

**Parameters**

- `NUM_PACKETS`, default 937: packets per recording.
- `ADDR_W`, default 10: memory address width. Must satisfy 2^ADDR_W ≥ NUM_PACKETS.

**Ports**

- `clk` in 1: single clock.
- `reset` in 1: reset, synchronous, active-high.
- `Play_butt` in 1: start or restart playback, sampled every cycle.
- `Rec_butt` in 1: abort playback, sampled every cycle.
- `bit_tick` in 1: one-cycle strobe per serial bit slot. Consecutive strobes are at least 3 cycles apart.
- `mem_rd_en` out 1: memory read strobe.
- `mem_addr` out ADDR_W: read address.
- `mem_rd_data` in 32: read data, valid exactly 1 cycle after `mem_rd_en`.
- `sdata_out` out 1: serial output bit.
- `bit_count` out 5: current bit index within the packet, 0..31.
- `packet_count` out 10: index of the packet being output.
- `prepacket` out 1: high during the prefetch slot.
- `playing` out 1: high while in PREPACKET or STREAM.
- `done` out 1: one-cycle pulse at the end of a recording.

## Operation

**States:** IDLE, PREPACKET, STREAM. Registers: `shift_reg[31:0]`, `next_buf[31:0]`.

**Priority, evaluated per cycle:**

1. `reset`
2. `Rec_butt`: go to IDLE.
3. `Play_butt`: go to PREPACKET, `bit_count=0`, `packet_count=0`.
4. `bit_tick` processing.

**IDLE**

- All outputs are 0.
- `bit_tick` is ignored.

**PREPACKET**

- In the first cycle after entry: `mem_rd_en=1`, `mem_addr=0`.
- The next cycle captures `mem_rd_data` into `next_buf`.
- Each tick increments `bit_count`.
- `sdata_out=0`. `prepacket=1`.
- On the tick with `bit_count==31`:
  - `shift_reg<=next_buf`, `bit_count<=0`, `packet_count<=0`, `prepacket<=0`.
  - State goes to STREAM.

**STREAM**

- `sdata_out = shift_reg[31]`.
- Tick with `bit_count<31`: shift `shift_reg` left by 1 and increment `bit_count`.
- Tick with `bit_count==31` and `packet_count<NUM_PACKETS-1`:
  - `shift_reg<=next_buf`, `packet_count+=1`, `bit_count<=0`.
  - The following cycle issues a read at address `packet_count` (new value) + 1, if that address is below `NUM_PACKETS`.
  - The cycle after that captures the data into `next_buf`.
- Tick with `bit_count==31` and `packet_count==NUM_PACKETS-1`:
  - State goes to IDLE and `done` pulses.
  - Counters clear to 0.

**Arithmetic**

- `bit_count` is 5-bit and wraps 31→0.
- `packet_count` never exceeds `NUM_PACKETS-1`.
- No read is ever issued at an address ≥ `NUM_PACKETS`.

## Timing

- **Reset values:** all outputs 0 and state IDLE. `shift_reg` and `next_buf` are 0.
- **Register updates:** all outputs are registered and update on the `clk` edge where the triggering event is sampled.
- **Play latency:** `Play_butt` in cycle n gives:
  - `playing=1` and `prepacket=1` in cycle n+1;
  - `mem_rd_en=1` in cycle n+1;
  - `next_buf` valid from cycle n+3.
- **First data bit:** the MSB of packet 0 appears on `sdata_out` in the cycle after the 32nd tick following entry.
- **Prefetch margin:** the prefetch completes 2 cycles after a load tick. With ≥3-cycle tick spacing, `next_buf` is always valid before the next load.
- **`Play_butt` mid-stream:** restarts the sequence, including a fresh prepacket. Any pending read data is discarded.
- **`Rec_butt` and `Play_butt` in the same cycle:** `Rec_butt` wins and the block goes to IDLE.
- **`reset` mid-operation:** returns to IDLE on the next edge. No `done` pulse.
- **`Play_butt` and `bit_tick` in the same cycle:** the tick is ignored.

## Configuration

`PLAYBACK_LOOP_EN`

- **Defined:** at the final packet's bit-31 tick:
  - `done` pulses;
  - the state stays in STREAM;
  - `shift_reg<=next_buf`, which holds packet 0;
  - `packet_count<=0`.
  - The prefetch after loading packet `NUM_PACKETS-1` reads address 0.
  - No new prepacket is inserted. Looping continues until `Rec_butt`, `Play_butt`, or `reset`.
- **Undefined:** behaviour is as specified in Operation, stopping in IDLE after one pass.

## Test plan

- **Single pass:** `Play_butt` pulse, then ticks every 4 cycles, memory word k = `{22'h0, k[9:0]}` (k in the low 10 bits, upper 22 bits 0).
  - `prepacket` is high for 32 ticks.
  - Then 937×32 bits match MSB-first.
  - `done` pulses once, after packet 936 bit 31. `playing` drops the same cycle.
- **Read pattern:** the same run, checking memory accesses.
  - Exactly 937 reads, at addresses 0..936 in order.
  - Each read is issued one cycle after a load tick (or after PREPACKET entry).
  - No read at address 937.
- **Abort:** `Rec_butt` during packet 500 bit 10.
  - The next cycle shows all outputs 0 and IDLE.
  - Subsequent ticks produce no change.
- **Restart:** `Play_butt` during packet 100.
  - `prepacket=1` and `packet_count=0` the next cycle.
  - The read address returns to 0 and the output resumes from packet 0.
- **Simultaneous events and reset:**
  - `Rec_butt` and `Play_butt` in the same cycle: IDLE.
  - `reset` mid-stream: all outputs 0 next cycle, with no `done` pulse.
- **`PLAYBACK_LOOP_EN` defined:**
  - After packet 936 the stream continues with packet 0 and no prepacket gap.
  - `done` pulses at each wrap.
